set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameters: ADDRESS_LEN, default 32, word-address width; WORD_LEN, default 32, data word width; BLOCK_WORDS, default 4, words per line (power of 2); SETS, default 1024, sets (power of 2); WAYS, default 2, associativity (1, 2 or 4).
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-004 SHALL have port cpu_req  input  1  access request; held by the requester until cpu_ready.
REQ-005 SHALL have port cpu_we  input  1  1=write, 0=read; sampled with cpu_req.
REQ-006 SHALL have port cpu_addr  input  ADDRESS_LEN  word address.
REQ-007 SHALL have port cpu_wdata  input  WORD_LEN  write data.
REQ-008 SHALL have port cpu_rdata  output  WORD_LEN  read data; valid only while cpu_ready=1.
REQ-009 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_rd_req  output  1  block refill request.
REQ-011 SHALL have port mem_wr_req  output  1  single-word write-through request.
REQ-012 SHALL have port mem_addr  output  ADDRESS_LEN  memory address: block-aligned for reads, word address for writes.
REQ-013 SHALL have port mem_wdata  output  WORD_LEN  write-through data.
REQ-014 SHALL have port mem_rdata  input  WORD_LEN*BLOCK_WORDS  refill block; word k at bits [k*WORD_LEN +: WORD_LEN].
REQ-015 SHALL have port mem_ready  input  1  memory completion; ignored unless a mem request is active.
REQ-016 SHALL have port hit_count  output  32  lookup hits since reset.
REQ-017 SHALL have port miss_count  output  32  lookup misses since reset.

Function
REQ-018 SHALL split cpu_addr into offset (low log2(BLOCK_WORDS) bits), index (next log2(SETS) bits) and tag (remaining bits).
REQ-019 SHALL store per set and way: a valid bit, a tag and BLOCK_WORDS data words; per set: a round-robin victim pointer of log2(WAYS) bits.
REQ-020 SHALL implement the FSM states IDLE, LOOKUP, REFILL and WRITE_MEM.
REQ-021 IDLE: cpu_req=1 SHALL register cpu_we, cpu_addr and cpu_wdata and go to LOOKUP; cpu_req is ignored in every other state.
REQ-022 LOOKUP: hit SHALL mean any way with valid=1 and a matching tag; each LOOKUP SHALL add 1 to exactly one of hit_count or miss_count, saturating at 0xFFFFFFFF.
REQ-023 Read hit: SHALL assert cpu_ready with the hit word in the LOOKUP cycle (ready 1 cycle after acceptance) and return to IDLE.
REQ-024 Read miss: SHALL go to REFILL and assert mem_rd_req with mem_addr = cpu_addr with its offset bits cleared, held until mem_ready.
REQ-025 REFILL on mem_ready: SHALL write the block, tag and valid=1 into the victim way, pulse cpu_ready with mem_rdata word[offset] in the same cycle, drop mem_rd_req and return to IDLE.
REQ-026 Victim SHALL be the lowest-index invalid way; if all ways are valid, the victim SHALL be the set's pointer way, and the pointer SHALL then increment modulo WAYS. The pointer SHALL NOT change when an invalid way is filled.
REQ-027 Write (write-through, no-write-allocate): on a hit, SHALL update that word in the line during LOOKUP; on hit or miss, SHALL go to WRITE_MEM. A write miss SHALL NOT allocate a line.
REQ-028 WRITE_MEM: SHALL assert mem_wr_req with mem_addr = cpu_addr and mem_wdata = cpu_wdata until mem_ready, then pulse cpu_ready and return to IDLE.
REQ-029 mem_rd_req and mem_wr_req SHALL never be 1 in the same cycle.
REQ-030 WAYS=1 SHALL behave as direct-mapped, with the pointer logic absent.

Reset
REQ-031 rst=0 SHALL, at the next rising clk edge, set the FSM to IDLE, clear all valid bits and pointers, set cpu_ready, mem_rd_req and mem_wr_req to 0, set cpu_rdata, mem_addr and mem_wdata to 0, and set both counters to 0.
REQ-032 Reset during REFILL or WRITE_MEM SHALL abandon the transaction without a cpu_ready pulse; a mem_ready that arrives later SHALL be ignored.

Verification
REQ-033 Reset: hold rst=0 for 1 cycle -> all outputs 0; hit_count=miss_count=0.
REQ-034 Cold read of 1024, with mem_ready 3 cycles after mem_rd_req and block {D3,D2,D1,D0} -> mem_addr=1024, cpu_rdata=D0, miss_count=1; a following read of 1025 -> cpu_ready 1 cycle after acceptance, cpu_rdata=D1, hit_count=1.
REQ-035 Conflict (defaults): read 0, 4096, 8192 (all set 0) -> three misses; read 4096 -> hit; read 0 -> miss (way0 was evicted by 8192).
REQ-036 After a fill of 1024, write 1025=0xDEADBEEF -> mem_wr_req=1, mem_addr=1025, mem_wdata=0xDEADBEEF; after mem_ready, a read of 1025 hits and returns 0xDEADBEEF; a write to 2048 followed by a read of 2048 -> the read misses.
REQ-037 Assert rst=0 while mem_rd_req=1 -> mem_rd_req=0 on the next cycle with no cpu_ready pulse; a subsequent read of the previously cached 1024 misses.
REQ-038 Sequential reads of 1024..9215 -> miss_count=2048, hit_count=6144, and every cpu_rdata matches the memory model.

Source files
------------

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//   Write-through, no-write-allocate, set-associative cache that sits between a
//   simple request/ready CPU port and a block-refill memory port. Each set holds
//   WAYS lines of BLOCK_WORDS words; replacement fills the lowest invalid way
//   first, then cycles a per-set round-robin pointer.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-low reset
//   cpu_req     access request, held until cpu_ready
//   cpu_we      1 = write, 0 = read
//   cpu_addr    word address
//   cpu_wdata   write data
//   cpu_rdata   read data, valid only while cpu_ready = 1
//   cpu_ready   one-cycle completion pulse
//   mem_rd_req  block refill request (mem_addr block-aligned)
//   mem_wr_req  single-word write-through request (mem_addr word address)
//   mem_addr    memory address
//   mem_wdata   write-through data
//   mem_rdata   refill block, word k at [k*WORD_LEN +: WORD_LEN]
//   mem_ready   memory completion, only observed while a request is active
//   hit_count   saturating count of lookup hits
//   miss_count  saturating count of lookup misses
//
// BLOCK_WORDS and SETS are expected to be powers of two of at least 2.
module set_assoc_cache #(
    parameter int ADDRESS_LEN = 32,
    parameter int WORD_LEN    = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 1024,
    parameter int WAYS        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDRESS_LEN-1:0]          cpu_addr,
    input  logic [WORD_LEN-1:0]             cpu_wdata,
    output logic [WORD_LEN-1:0]             cpu_rdata,
    output logic                            cpu_ready,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [ADDRESS_LEN-1:0]          mem_addr,
    output logic [WORD_LEN-1:0]             mem_wdata,
    input  logic [WORD_LEN*BLOCK_WORDS-1:0] mem_rdata,
    input  logic                            mem_ready,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_LEN - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE_MEM
    } state_t;

    state_t state;
    state_t state_next;

    // Request captured in IDLE; everything after IDLE works from these copies.
    logic                   req_we;
    logic [ADDRESS_LEN-1:0] req_addr;
    logic [WORD_LEN-1:0]    req_wdata;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    assign req_off = req_addr[OFF_W-1:0];
    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDRESS_LEN-1 -: TAG_W];

    // Line storage
    logic [WAYS-1:0]     valid [SETS];
    logic [TAG_W-1:0]    tags  [SETS][WAYS];
    logic [WORD_LEN-1:0] data  [SETS][WAYS][BLOCK_WORDS];

    // Hit detection: lowest matching way wins (only one can match in practice).
    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim selection: lowest invalid way, else the set's round-robin pointer.
    logic             all_valid;
    logic [WAY_W-1:0] ptr_cur;
    logic [WAY_W-1:0] victim;

    always_comb begin
        all_valid = &valid[req_idx];
        victim    = ptr_cur;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // A refill completes, or a write hit updates a word. Both are suppressed
    // while rst is low so a transaction abandoned by reset leaves no trace.
    logic fill;
    logic wr_hit;

    assign fill   = rst && (state == REFILL) && mem_ready;
    assign wr_hit = rst && (state == LOOKUP) && req_we && hit;

    generate
        if (WAYS > 1) begin : g_ptr
            logic [WAY_W-1:0] ptr [SETS];

            // The pointer only advances when a valid line is evicted.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        ptr[s] <= '0;
                    end
                end else if (fill && all_valid) begin
                    ptr[req_idx] <= ptr[req_idx] + WAY_W'(1);
                end
            end

            assign ptr_cur = ptr[req_idx];
        end else begin : g_no_ptr
            assign ptr_cur = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
            end
        end else if (fill) begin
            valid[req_idx][victim] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately left without reset; the valid
    // bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[req_idx][victim] <= req_tag;
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                data[req_idx][victim][k] <= mem_rdata[k*WORD_LEN +: WORD_LEN];
            end
        end else if (wr_hit) begin
            data[req_idx][hit_way][req_off] <= req_wdata;
        end
    end

    // Request capture and hit/miss counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                if (hit) begin
                    if (hit_count != 32'hFFFF_FFFF) begin
                        hit_count <= hit_count + 32'd1;
                    end
                end else if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and outputs. All outputs decode from the current state,
    // so they read as zero whenever the FSM sits in IDLE after reset.
    // cpu_ready is qualified with rst so an abandoned transaction never
    // completes, even if mem_ready lands in the reset cycle.
    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = LOOKUP;
                end
            end

            LOOKUP: begin
                if (req_we) begin
                    state_next = WRITE_MEM;
                end else if (hit) begin
                    cpu_ready  = rst;
                    cpu_rdata  = data[req_idx][hit_way][req_off];
                    state_next = IDLE;
                end else begin
                    state_next = REFILL;
                end
            end

            REFILL: begin
                mem_rd_req = 1'b1;
                mem_addr   = {req_addr[ADDRESS_LEN-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_ready) begin
                    cpu_ready = rst;
                    for (int k = 0; k < BLOCK_WORDS; k++) begin
                        if (req_off == OFF_W'(k)) begin
                            cpu_rdata = mem_rdata[k*WORD_LEN +: WORD_LEN];
                        end
                    end
                    state_next = IDLE;
                end
            end

            WRITE_MEM: begin
                mem_wr_req = 1'b1;
                mem_addr   = req_addr;
                mem_wdata  = req_wdata;
                if (mem_ready) begin
                    cpu_ready  = rst;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache
//   Self-checking bench for set_assoc_cache at default parameters. A memory
//   responder answers refill and write-through requests after a programmable
//   latency. Directed vectors cover cold fill, hits, set conflicts and
//   write-through; hand sequences cover reset behaviour; a random phase is
//   compared against a tag-only cache model (cached data always equals memory
//   under write-through); a sequential sweep checks the final counters.
module tb_set_assoc_cache;

    localparam int SETS = 1024;
    localparam int WAYS = 2;
    localparam int BW   = 4;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    set_assoc_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT event did not occur within its bound", name);
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_over [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endfunction

    int mem_lat      = 3;
    bit resp_on      = 1'b1;
    bit inject_ready = 1'b0;

    // Responder acts 2 time units after each rising edge, after the DUT has
    // settled and after the main sequence has driven its inputs.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (inject_ready) begin
                mem_ready    = 1'b1;
                inject_ready = 1'b0;
            end else if (resp_on && (mem_rd_req || mem_wr_req)) begin
                if (cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    cnt       = 0;
                    if (mem_rd_req) begin
                        for (int k = 0; k < BW; k++) begin
                            mem_rdata[k*32 +: 32] = mem_word(mem_addr + 32'(k));
                        end
                    end else begin
                        mem_over[mem_addr] = mem_wdata;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- cache reference model (tags only) ----------------
    bit          model_valid [SETS][WAYS];
    int unsigned model_tag   [SETS][WAYS];
    int          model_ptr   [SETS];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            model_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) model_valid[s][w] = 1'b0;
        end
    endtask

    // Returns 1 on hit; applies the allocation rules on a read miss.
    function automatic bit model_access(input bit we, input logic [31:0] a);
        int          s;
        int unsigned t;
        s = int'(a[11:2]);
        t = int'(a[31:12]);
        for (int w = 0; w < WAYS; w++)
            if (model_valid[s][w] && model_tag[s][w] == t) return 1'b1;
        if (we) return 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!model_valid[s][w]) begin
                model_valid[s][w] = 1'b1;
                model_tag[s][w]   = t;
                return 1'b0;
            end
        end
        model_tag[s][model_ptr[s]] = t;
        model_ptr[s] = (model_ptr[s] + 1) % WAYS;
        return 1'b0;
    endfunction

    // ---------------- CPU access driver ----------------
    logic [31:0] seen_rd_addr;
    logic [31:0] seen_wr_addr;
    logic [31:0] seen_wr_data;
    bit          both_req_seen = 1'b0;

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        bit done;
        done         = 1'b0;
        rdata        = '0;
        lat          = 0;
        seen_rd_addr = 32'hFFFF_FFFF;
        seen_wr_addr = 32'hFFFF_FFFF;
        seen_wr_data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (mem_rd_req && mem_wr_req) both_req_seen = 1'b1;
            if (mem_rd_req) seen_rd_addr = mem_addr;
            if (mem_wr_req) begin
                seen_wr_addr = mem_addr;
                seen_wr_data = mem_wdata;
            end
            if (cpu_ready) begin
                rdata = cpu_rdata;
                done  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        if (!done) fail_now($sformatf("access_timeout_%0h", addr));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] rd;
        logic [31:0] h0;
        logic [31:0] m0;
        int          lat;
        int          exp_lat;
        bit          hit;
        bit          seen_bad;
        int          exp_hits;
        int          exp_misses;

        // {we, addr, wdata, expected hit, expected read data}
        vecs[0]  = '{1'b0, 32'd1024, 32'd0,           1'b0, mem_word(32'd1024)};
        vecs[1]  = '{1'b0, 32'd1025, 32'd0,           1'b1, mem_word(32'd1025)};
        vecs[2]  = '{1'b0, 32'd0,    32'd0,           1'b0, mem_word(32'd0)};
        vecs[3]  = '{1'b0, 32'd4096, 32'd0,           1'b0, mem_word(32'd4096)};
        vecs[4]  = '{1'b0, 32'd8192, 32'd0,           1'b0, mem_word(32'd8192)};
        vecs[5]  = '{1'b0, 32'd4096, 32'd0,           1'b1, mem_word(32'd4096)};
        vecs[6]  = '{1'b0, 32'd0,    32'd0,           1'b0, mem_word(32'd0)};
        vecs[7]  = '{1'b1, 32'd1025, 32'hDEAD_BEEF,   1'b1, 32'd0};
        vecs[8]  = '{1'b0, 32'd1025, 32'd0,           1'b1, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 32'd2048, 32'h1234_5678,   1'b0, 32'd0};
        vecs[10] = '{1'b0, 32'd2048, 32'd0,           1'b0, 32'h1234_5678};

        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        // Reset: one rising edge with rst low clears every output.
        @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready",  32'(cpu_ready),  32'd0);
        check("rst_cpu_rdata",  cpu_rdata,       32'd0);
        check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_hit_count",  hit_count,       32'd0);
        check("rst_miss_count", miss_count,      32'd0);
        #1;
        rst = 1'b1;
        model_reset();

        // Directed table
        mem_lat = 3;
        for (int i = 0; i < 11; i++) begin
            h0 = hit_count;
            m0 = miss_count;
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
            exp_lat = (!vecs[i].we && vecs[i].exp_hit) ? 2 : 3 + mem_lat;
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("vec%0d_hit_inc", i),  hit_count - h0,  32'(vecs[i].exp_hit));
            check($sformatf("vec%0d_miss_inc", i), miss_count - m0, 32'(!vecs[i].exp_hit));
            if (!vecs[i].we) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                if (!vecs[i].exp_hit)
                    check($sformatf("vec%0d_refill_addr", i), seen_rd_addr, vecs[i].addr & ~32'd3);
            end else begin
                check($sformatf("vec%0d_wr_addr", i), seen_wr_addr, vecs[i].addr);
                check($sformatf("vec%0d_wr_data", i), seen_wr_data, vecs[i].wdata);
            end
        end

        // Reset in the middle of a refill: 5120 maps to the set holding 1024.
        resp_on = 1'b0;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'd5120;
        hit      = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (mem_rd_req) hit = 1'b1;
        end
        if (!hit) fail_now("abort_wait_rd_req");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("abort_no_ready_in_rst_cycle", 32'(cpu_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("abort_rd_req_dropped", 32'(mem_rd_req), 32'd0);
        check("abort_cpu_ready",      32'(cpu_ready),  32'd0);
        check("abort_miss_cleared",   miss_count,      32'd0);
        check("abort_hit_cleared",    hit_count,       32'd0);
        // A stray late mem_ready must not produce a completion.
        @(posedge clk);
        #1;
        inject_ready = 1'b1;
        seen_bad     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ready || mem_rd_req || mem_wr_req) seen_bad = 1'b1;
        end
        check("late_mem_ready_ignored", 32'(seen_bad), 32'd0);
        resp_on = 1'b1;
        access(1'b0, 32'd1024, 32'd0, rd, lat);
        check("post_abort_1024_miss",  miss_count, 32'd1);
        check("post_abort_1024_hits",  hit_count,  32'd0);
        check("post_abort_1024_rdata", rd, mem_word(32'd1024));

        // Random accesses against the reference model
        do_reset();
        exp_hits   = 0;
        exp_misses = 0;
        for (int i = 0; i < 300; i++) begin
            bit          we;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] exp_rd;
            we      = ($urandom_range(0, 9) < 3);
            a       = (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 3)) << 2)
                      | 32'($urandom_range(0, 3));
            wd      = $urandom;
            mem_lat = $urandom_range(0, 3);
            exp_rd  = mem_word(a);
            hit     = model_access(we, a);
            if (hit) exp_hits++;
            else     exp_misses++;
            h0 = hit_count;
            access(we, a, wd, rd, lat);
            check($sformatf("rand%0d_hit", i), hit_count - h0, 32'(hit));
            if (!we) check($sformatf("rand%0d_rdata_%0h", i, a), rd, exp_rd);
        end
        check("rand_hit_total",  hit_count,  32'(exp_hits));
        check("rand_miss_total", miss_count, 32'(exp_misses));

        // Sequential sweep 1024..9215: two blocks per set, no evictions.
        do_reset();
        mem_lat = 0;
        for (int a = 1024; a <= 9215; a++) begin
            access(1'b0, 32'(a), 32'd0, rd, lat);
            check($sformatf("seq_rdata_%0d", a), rd, mem_word(32'(a)));
        end
        check("seq_miss_count", miss_count, 32'd2048);
        check("seq_hit_count",  hit_count,  32'd6144);

        check("rd_wr_never_together", 32'(both_req_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
